// File: rtl/pixel_stream_source.sv
// pixel_stream_source
//   Transmit end of the pixel-stream interface feeding the detection pipeline.
//   Generates FRAME_WIDTH x FRAME_HEIGHT raster timing with V and H blanking,
//   sourcing pixels either from an upstream valid/ready port or from a
//   built-in test pattern (colour bars, gray ramp, checkerboard).
//
//   State table:
//     state  | meaning
//     IDLE   | no frame in progress; waits for run
//     VBLANK | frame blanking, V_BLANK*(FRAME_WIDTH+H_BLANK) cycles
//     HBLANK | line blanking, H_BLANK cycles before each active line
//     ACTIVE | emitting FRAME_WIDTH pixels (stalls on upstream gaps)
//
// Ports
//   clk        in   clock
//   reset_n    in   asynchronous active-low reset
//   run        in   level; frames repeat back to back while high
//   src_sel    in   0=upstream, 1=colour bars, 2=gray ramp, 3=checkerboard
//   s_data     in   upstream pixel (R=[7:0], G=[15:8], B=[23:16])
//   s_valid    in   upstream pixel valid
//   s_ready    out  upstream pixel accepted when s_valid && s_ready
//   en         out  pixel strobe
//   hsync      out  pulse on first cycle of each line's H blank
//   vsync      out  pulse on first cycle of frame V blank
//   data       out  pixel, zero when en is low
//   frame_done out  pulse with the en of the last pixel of a frame
module pixel_stream_source #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int H_BLANK      = 16,
  parameter int V_BLANK      = 2,
  parameter int PIXEL_SIZE   = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic [1:0]            src_sel,
  input  logic [PIXEL_SIZE-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  en,
  output logic                  hsync,
  output logic                  vsync,
  output logic [PIXEL_SIZE-1:0] data,
  output logic                  frame_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VBLANK = 2'd1,
    HBLANK = 2'd2,
    ACTIVE = 2'd3
  } state_t;

  // Blank timers are down-counters loaded with (length-1); terminal count is 0.
  localparam logic [31:0] VB_LOAD = 32'(V_BLANK * (FRAME_WIDTH + H_BLANK) - 1);
  localparam logic [31:0] HB_LOAD = 32'(H_BLANK - 1);
  localparam logic [15:0] X_LAST  = 16'(FRAME_WIDTH - 1);
  localparam logic [15:0] Y_LAST  = 16'(FRAME_HEIGHT - 1);
  localparam logic [15:0] BAR_W   = 16'(FRAME_WIDTH / 8);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [1:0]  sel_q, sel_d;

  logic        pix_go;
  logic        line_end;
  logic        frame_end;
  logic        hs_first;
  logic        vs_first;
  logic [2:0]  bar;
  logic [23:0] pat;
  logic [PIXEL_SIZE-1:0] pix;

  // Pattern sources never stall; upstream advances only on a handshake.
  assign s_ready   = (state_q == ACTIVE) && (sel_q == 2'd0);
  assign pix_go    = (state_q == ACTIVE) && ((sel_q != 2'd0) || s_valid);
  assign line_end  = pix_go && (x_q == X_LAST);
  assign frame_end = line_end && (y_q == Y_LAST);

  // Timers start at their load value, so the load value marks the first cycle.
  assign hs_first  = (state_q == HBLANK) && (cnt_q == HB_LOAD);
  assign vs_first  = (state_q == VBLANK) && (cnt_q == VB_LOAD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = VBLANK;
          cnt_d   = VB_LOAD;
          sel_d   = src_sel;
        end
      end
      VBLANK: begin
        if (cnt_q == 32'd0) begin
          state_d = HBLANK;
          cnt_d   = HB_LOAD;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      HBLANK: begin
        if (cnt_q == 32'd0) begin
          state_d = ACTIVE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      ACTIVE: begin
        if (pix_go) begin
          if (line_end) begin
            x_d = 16'd0;
            if (frame_end) begin
              y_d = 16'd0;
              if (run) begin
                state_d = VBLANK;
                cnt_d   = VB_LOAD;
                sel_d   = src_sel;
              end else begin
                state_d = IDLE;
              end
            end else begin
              y_d     = y_q + 16'd1;
              state_d = HBLANK;
              cnt_d   = HB_LOAD;
            end
          end else begin
            x_d = x_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bar = 3'(x_q / BAR_W);

  always_comb begin
    pat = 24'h000000;
    case (sel_q)
      2'd1: begin
        case (bar)
          3'd0:    pat = 24'hFFFFFF;  // white
          3'd1:    pat = 24'h00FFFF;  // yellow
          3'd2:    pat = 24'hFFFF00;  // cyan
          3'd3:    pat = 24'h00FF00;  // green
          3'd4:    pat = 24'hFF00FF;  // magenta
          3'd5:    pat = 24'h0000FF;  // red
          3'd6:    pat = 24'hFF0000;  // blue
          default: pat = 24'h000000;  // black
        endcase
      end
      2'd2:    pat = {3{x_q[7:0]}};
      2'd3:    pat = (x_q[3] ^ y_q[3]) ? 24'hFFFFFF : 24'h000000;
      default: pat = 24'h000000;
    endcase
  end

  assign pix = (sel_q == 2'd0) ? s_data : PIXEL_SIZE'(pat);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      sel_q      <= '0;
      en         <= 1'b0;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      data       <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      sel_q      <= sel_d;
      en         <= pix_go;
      hsync      <= hs_first;
      vsync      <= vs_first;
      data       <= pix_go ? pix : '0;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_pixel_stream_source.sv
module tb_pixel_stream_source;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int HB = 2;
  localparam int VB = 1;
  localparam int PS = 24;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          run;
  logic [1:0]    src_sel;
  logic [PS-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          en;
  logic          hsync;
  logic          vsync;
  logic [PS-1:0] data;
  logic          frame_done;

  logic          run2;
  logic [1:0]    sel2;
  logic [PS-1:0] s_data2;
  logic          s_valid2;
  logic          s_ready2;
  logic          en2;
  logic          hsync2;
  logic          vsync2;
  logic [PS-1:0] data2;
  logic          frame_done2;

  always #5 clk = ~clk;

  pixel_stream_source #(
    .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .H_BLANK(HB), .V_BLANK(VB), .PIXEL_SIZE(PS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .src_sel(src_sel),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .en(en), .hsync(hsync), .vsync(vsync), .data(data), .frame_done(frame_done)
  );

  pixel_stream_source #(
    .FRAME_WIDTH(16), .FRAME_HEIGHT(H), .H_BLANK(HB), .V_BLANK(VB), .PIXEL_SIZE(PS)
  ) dut_w16 (
    .clk(clk), .reset_n(reset_n), .run(run2), .src_sel(sel2),
    .s_data(s_data2), .s_valid(s_valid2), .s_ready(s_ready2),
    .en(en2), .hsync(hsync2), .vsync(vsync2), .data(data2), .frame_done(frame_done2)
  );

  int checks = 0;
  int errors = 0;

  int          en_k[$];
  logic [23:0] en_d[$];
  int          hs_k[$];
  int          vs_k[$];
  int          fd_k[$];
  int          bad_cnt;
  int          rdy_cnt;

  logic [23:0] bar_tab [8];

  // Starts run at the current negedge (sample 0) and records output events
  // at the following ncyc negedges, indexed 1..ncyc.
  task automatic capture(input int ncyc, input logic [1:0] sel0, input int run_off_k,
                         input int sel_k, input logic [1:0] sel_new);
    en_k.delete(); en_d.delete(); hs_k.delete(); vs_k.delete(); fd_k.delete();
    bad_cnt = 0;
    rdy_cnt = 0;
    src_sel = sel0;
    run     = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (en) begin
        en_k.push_back(k);
        en_d.push_back(data);
      end
      if (hsync) hs_k.push_back(k);
      if (vsync) vs_k.push_back(k);
      if (frame_done) fd_k.push_back(k);
      if ((!en && data !== '0) || (en && (hsync || vsync))) bad_cnt++;
      if (s_ready) rdy_cnt++;
      if (k == run_off_k) run = 1'b0;
      if (k == sel_k) src_sel = sel_new;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    run     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({en, hsync, vsync, frame_done, s_ready} !== 5'b0 || data !== '0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got en/hs/vs/fd/rdy=%b data=%h want 0", i,
                 {en, hsync, vsync, frame_done, s_ready}, data);
      end
    end
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({en, hsync, vsync, frame_done, s_ready} !== 5'b0 || data !== '0) begin
        errors++;
        $display("FAIL idle cyc=%0d got en/hs/vs/fd/rdy=%b data=%h want 0", i,
                 {en, hsync, vsync, frame_done, s_ready}, data);
      end
    end
  endtask

  task automatic test_gray();
    int vs0, fd0;
    @(negedge clk);
    capture(60, 2'd2, 3, -1, 2'd0);
    vs0 = (vs_k.size() > 0) ? vs_k[0] : -1;
    checks++;
    if (vs_k.size() != 1 || vs0 != 2) begin
      errors++;
      $display("FAIL gray_vsync got count=%0d first=%0d want count=1 at 2", vs_k.size(), vs0);
    end
    checks++;
    if (hs_k.size() != H) begin
      errors++;
      $display("FAIL gray_hsync_count got %0d want %0d", hs_k.size(), H);
    end
    for (int i = 0; i < hs_k.size() && i < H; i++) begin
      checks++;
      if (hs_k[i] != 12 + 10 * i) begin
        errors++;
        $display("FAIL gray_hsync_pos line=%0d got %0d want %0d", i, hs_k[i], 12 + 10 * i);
      end
    end
    checks++;
    if (en_k.size() != 32) begin
      errors++;
      $display("FAIL gray_en_count got %0d want 32", en_k.size());
    end
    for (int p = 0; p < en_k.size() && p < 32; p++) begin
      checks++;
      if (en_k[p] != 14 + (p / 8) * 10 + (p % 8)) begin
        errors++;
        $display("FAIL gray_en_pos p=%0d got %0d want %0d", p, en_k[p], 14 + (p / 8) * 10 + (p % 8));
      end
      checks++;
      if (en_d[p] !== {3{8'(p % 8)}}) begin
        errors++;
        $display("FAIL gray_data p=%0d got %h want %h", p, en_d[p], {3{8'(p % 8)}});
      end
    end
    fd0 = (fd_k.size() > 0) ? fd_k[0] : -1;
    checks++;
    if (fd_k.size() != 1 || fd0 != 51) begin
      errors++;
      $display("FAIL gray_frame_done got count=%0d first=%0d want count=1 at 51", fd_k.size(), fd0);
    end
    checks++;
    if (bad_cnt != 0 || rdy_cnt != 0) begin
      errors++;
      $display("FAIL gray_hygiene got bad=%0d ready=%0d want 0 0", bad_cnt, rdy_cnt);
    end
  endtask

  task automatic test_bars();
    @(negedge clk);
    capture(60, 2'd1, 3, -1, 2'd0);
    checks++;
    if (en_k.size() != 32) begin
      errors++;
      $display("FAIL bars_en_count got %0d want 32", en_k.size());
    end
    for (int p = 0; p < en_d.size() && p < 32; p++) begin
      checks++;
      if (en_d[p] !== bar_tab[p % 8]) begin
        errors++;
        $display("FAIL bars_data p=%0d got %h want %h", p, en_d[p], bar_tab[p % 8]);
      end
    end
    checks++;
    if (bad_cnt != 0 || rdy_cnt != 0 || hs_k.size() != H) begin
      errors++;
      $display("FAIL bars_hygiene got bad=%0d ready=%0d hs=%0d want 0 0 %0d",
               bad_cnt, rdy_cnt, hs_k.size(), H);
    end
  endtask

  task automatic test_checker();
    logic [23:0] got[$];
    logic [23:0] want;
    int          bad2;
    int          fd2;
    @(negedge clk);
    sel2 = 2'd3;
    run2 = 1'b1;
    bad2 = 0;
    fd2  = 0;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      if (k == 3) run2 = 1'b0;
      if (en2) got.push_back(data2);
      if (s_ready2 || (en2 && (hsync2 || vsync2))) bad2++;
      if (frame_done2) fd2++;
    end
    checks++;
    if (got.size() != 64) begin
      errors++;
      $display("FAIL checker_en_count got %0d want 64", got.size());
    end
    for (int p = 0; p < got.size() && p < 64; p++) begin
      want = ((p % 16) >= 8) ? 24'hFFFFFF : 24'h000000;
      checks++;
      if (got[p] !== want) begin
        errors++;
        $display("FAIL checker_data p=%0d got %h want %h", p, got[p], want);
      end
    end
    checks++;
    if (bad2 != 0 || fd2 != 1) begin
      errors++;
      $display("FAIL checker_hygiene got bad=%0d frame_done=%0d want 0 1", bad2, fd2);
    end
  endtask

  task automatic test_upstream();
    int          next_val, en_cnt, hs_cnt, fd_cnt, fd_at, first_rdy, tail, late_rdy, k;
    logic        exp_en;
    logic [23:0] exp_d;
    @(negedge clk);
    src_sel   = 2'd0;
    run       = 1'b1;
    s_valid   = 1'b0;
    next_val  = 0;
    en_cnt    = 0;
    hs_cnt    = 0;
    fd_cnt    = 0;
    fd_at     = -1;
    first_rdy = -1;
    tail      = 0;
    late_rdy  = 0;
    k         = 0;
    exp_en    = 1'b0;
    exp_d     = 24'h0;
    while (k < 600 && tail < 20) begin
      @(negedge clk);
      k++;
      if (k == 3) run = 1'b0;
      checks++;
      if (en !== exp_en || data !== (exp_en ? exp_d : 24'h0)) begin
        errors++;
        $display("FAIL upstream_out k=%0d got en=%b data=%h want en=%b data=%h",
                 k, en, data, exp_en, exp_en ? exp_d : 24'h0);
      end
      if (en) en_cnt++;
      if (hsync) hs_cnt++;
      if (frame_done) begin
        fd_cnt++;
        fd_at = en_cnt;
      end
      if (s_ready && first_rdy < 0) first_rdy = k;
      if (next_val >= 32) begin
        tail++;
        if (s_ready) late_rdy++;
      end
      s_valid = ($urandom_range(0, 2) != 0);
      s_data  = (next_val < 32) ? 24'(next_val) : 24'hABCDEF;
      exp_en  = s_valid && s_ready;
      exp_d   = s_data;
      if (exp_en) next_val++;
    end
    s_valid = 1'b0;
    checks++;
    if (next_val != 32) begin
      errors++;
      $display("FAIL upstream_timeout got %0d handshakes want 32", next_val);
    end
    checks++;
    if (en_cnt != 32 || hs_cnt != H) begin
      errors++;
      $display("FAIL upstream_counts got en=%0d hs=%0d want 32 %0d", en_cnt, hs_cnt, H);
    end
    checks++;
    if (fd_cnt != 1 || fd_at != 32) begin
      errors++;
      $display("FAIL upstream_frame_done got count=%0d at_en=%0d want 1 32", fd_cnt, fd_at);
    end
    checks++;
    if (first_rdy != 13) begin
      errors++;
      $display("FAIL upstream_first_ready got %0d want 13", first_rdy);
    end
    checks++;
    if (late_rdy != 0) begin
      errors++;
      $display("FAIL upstream_idle_ready got %0d want 0", late_rdy);
    end
  endtask

  task automatic test_continuous();
    int          f, l, x, pos;
    logic [23:0] want;
    @(negedge clk);
    capture(170, 2'd2, 120, 30, 2'd1);
    checks++;
    if (vs_k.size() != 3) begin
      errors++;
      $display("FAIL cont_vsync_count got %0d want 3", vs_k.size());
    end
    for (int i = 0; i < vs_k.size() && i < 3; i++) begin
      checks++;
      if (vs_k[i] != 2 + 50 * i) begin
        errors++;
        $display("FAIL cont_vsync_pos frame=%0d got %0d want %0d", i, vs_k[i], 2 + 50 * i);
      end
    end
    checks++;
    if (fd_k.size() != 3) begin
      errors++;
      $display("FAIL cont_fd_count got %0d want 3", fd_k.size());
    end
    for (int i = 0; i < fd_k.size() && i < 3; i++) begin
      checks++;
      if (fd_k[i] != 51 + 50 * i) begin
        errors++;
        $display("FAIL cont_fd_pos frame=%0d got %0d want %0d", i, fd_k[i], 51 + 50 * i);
      end
    end
    checks++;
    if (en_k.size() != 96) begin
      errors++;
      $display("FAIL cont_en_count got %0d want 96", en_k.size());
    end
    for (int p = 0; p < en_k.size() && p < 96; p++) begin
      f    = p / 32;
      l    = (p % 32) / 8;
      x    = p % 8;
      pos  = 14 + 50 * f + 10 * l + x;
      want = (f == 0) ? {3{8'(x)}} : bar_tab[x];
      checks++;
      if (en_k[p] != pos || en_d[p] !== want) begin
        errors++;
        $display("FAIL cont_pixel p=%0d got k=%0d data=%h want k=%0d data=%h",
                 p, en_k[p], en_d[p], pos, want);
      end
    end
    checks++;
    if (bad_cnt != 0) begin
      errors++;
      $display("FAIL cont_hygiene got %0d want 0", bad_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    int found;
    int vs0, fd0;
    @(negedge clk);
    src_sel = 2'd2;
    run     = 1'b1;
    cnt     = 0;
    found   = 0;
    for (int k = 1; k <= 100 && found == 0; k++) begin
      @(negedge clk);
      if (en) begin
        cnt++;
        if (cnt == 22) found = 1;
      end
    end
    checks++;
    if (found == 0 || data !== 24'h050505) begin
      errors++;
      $display("FAIL rstmid_target got found=%0d data=%h want 1 050505", found, data);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({en, hsync, vsync, frame_done, s_ready} !== 5'b0 || data !== '0) begin
      errors++;
      $display("FAIL rstmid_immediate got en/hs/vs/fd/rdy=%b data=%h want 0",
               {en, hsync, vsync, frame_done, s_ready}, data);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({en, hsync, vsync, frame_done, s_ready} !== 5'b0 || data !== '0) begin
      errors++;
      $display("FAIL rstmid_held got en/hs/vs/fd/rdy=%b data=%h want 0",
               {en, hsync, vsync, frame_done, s_ready}, data);
    end
    reset_n = 1'b1;
    capture(60, 2'd2, 3, -1, 2'd0);
    vs0 = (vs_k.size() > 0) ? vs_k[0] : -1;
    fd0 = (fd_k.size() > 0) ? fd_k[0] : -1;
    checks++;
    if (vs_k.size() != 1 || vs0 != 2) begin
      errors++;
      $display("FAIL rstmid_vsync got count=%0d first=%0d want 1 at 2", vs_k.size(), vs0);
    end
    checks++;
    if (en_k.size() != 32 || en_k[0] != 14 || en_d[0] !== 24'h000000) begin
      errors++;
      $display("FAIL rstmid_restart got en=%0d first_k=%0d first_data=%h want 32 14 000000",
               en_k.size(), (en_k.size() > 0) ? en_k[0] : -1,
               (en_d.size() > 0) ? en_d[0] : 24'hXXXXXX);
    end
    checks++;
    if (fd_k.size() != 1 || fd0 != 51) begin
      errors++;
      $display("FAIL rstmid_frame_done got count=%0d first=%0d want 1 at 51", fd_k.size(), fd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bar_tab[0] = 24'hFFFFFF;
    bar_tab[1] = 24'h00FFFF;
    bar_tab[2] = 24'hFFFF00;
    bar_tab[3] = 24'h00FF00;
    bar_tab[4] = 24'hFF00FF;
    bar_tab[5] = 24'h0000FF;
    bar_tab[6] = 24'hFF0000;
    bar_tab[7] = 24'h000000;
    reset_n  = 1'b0;
    run      = 1'b0;
    src_sel  = 2'd0;
    s_data   = '0;
    s_valid  = 1'b0;
    run2     = 1'b0;
    sel2     = 2'd3;
    s_data2  = '0;
    s_valid2 = 1'b0;

    test_reset();
    test_gray();
    test_bars();
    test_checker();
    test_upstream();
    test_continuous();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
